// File: rtl/keypad_pkg.sv
// Shared types, key indices and helpers for the keypad number entry block.
// Optional backspace key is enabled by defining KEYPAD_BACKSPACE_EN.
package keypad_pkg;

`ifdef KEYPAD_BACKSPACE_EN
    localparam int unsigned NUM_KEYS = 13;
`else
    localparam int unsigned NUM_KEYS = 12;
`endif

    localparam int unsigned KEY_ZERO      = 0;
    localparam int unsigned KEY_ONE       = 1;
    localparam int unsigned KEY_TWO       = 2;
    localparam int unsigned KEY_THREE     = 3;
    localparam int unsigned KEY_FOUR      = 4;
    localparam int unsigned KEY_FIVE      = 5;
    localparam int unsigned KEY_SIX       = 6;
    localparam int unsigned KEY_SEVEN     = 7;
    localparam int unsigned KEY_EIGHT     = 8;
    localparam int unsigned KEY_NINE      = 9;
    localparam int unsigned KEY_CLEAR     = 10;
    localparam int unsigned KEY_ENTER     = 11;
    localparam int unsigned KEY_BACKSPACE = 12;

    typedef logic [3:0] digit_t;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        COMMIT,
        WAIT_RELEASE
    } state_t;

    // Digit keys occupy bits 0..9, so the set bit index is the digit value.
    function automatic digit_t onehot_to_digit(input logic [9:0] onehot);
        digit_t d;
        d = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (onehot[i]) begin
                d = 4'(i);
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Single-key debouncer: accepts a one-hot key after DEBOUNCE_CYCLES stable samples,
// flags it for one COMMIT cycle, then waits for all keys to be released.
module key_debouncer
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] keys,
    output logic                accept,
    output logic [NUM_KEYS-1:0] key_code,
    output logic                busy
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t              state_q, state_d;
    logic [NUM_KEYS-1:0] key_q, key_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                accept_q, accept_d;
    logic                busy_q, busy_d;
    logic                single_c;

    assign single_c = ($countones(keys) == 1);

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (single_c) begin
                    key_d   = keys;
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                // Any deviation from the captured key abandons the press silently.
                if (keys == key_q) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = COMMIT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            COMMIT: begin
                state_d = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (keys == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        accept_d = (state_d == COMMIT);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            key_q    <= '0;
            cnt_q    <= '0;
            accept_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            cnt_q    <= cnt_d;
            accept_q <= accept_d;
            busy_q   <= busy_d;
        end
    end

    assign accept   = accept_q;
    assign key_code = key_q;
    assign busy     = busy_q;

endmodule

// File: rtl/keypad_number_entry.sv
// Decimal number entry from a 10-key pad with CLEAR/ENTER; commits debounced keys
// into number/result. Define KEYPAD_BACKSPACE_EN to add the backspace key.
module keypad_number_entry
    import keypad_pkg::*;
#(
    parameter int unsigned NUMBER_WIDTH    = 16,
    parameter int unsigned MAX_DIGITS      = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 3
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 zero,
    input  logic                                 one,
    input  logic                                 two,
    input  logic                                 three,
    input  logic                                 four,
    input  logic                                 five,
    input  logic                                 six,
    input  logic                                 seven,
    input  logic                                 eight,
    input  logic                                 nine,
    input  logic                                 clear,
    input  logic                                 enter,
`ifdef KEYPAD_BACKSPACE_EN
    input  logic                                 backspace,
`endif
    output logic [NUMBER_WIDTH-1:0]              number,
    output logic [$clog2(MAX_DIGITS+1)-1:0]      digit_count,
    output logic                                 overflow,
    output logic                                 busy,
    output logic [NUMBER_WIDTH-1:0]              result,
    output logic                                 result_valid,
    output logic                                 result_error
);

    localparam int unsigned NW    = NUMBER_WIDTH;
    localparam int unsigned DC_W  = $clog2(MAX_DIGITS + 1);
    localparam int unsigned EXT_W = NUMBER_WIDTH + 4;
    localparam logic [EXT_W-1:0] EXT_MAX = {4'b0000, {NUMBER_WIDTH{1'b1}}};

    logic [NUM_KEYS-1:0] keys_c;
    logic [NUM_KEYS-1:0] key_code;
    logic                accept;

    logic [NW-1:0]   number_q, number_d;
    logic [DC_W-1:0] dc_q, dc_d;
    logic            ovf_q, ovf_d;
    logic [NW-1:0]   result_q, result_d;
    logic            valid_q, valid_d;
    logic            error_q, error_d;

    digit_t          digit_c;
    logic [EXT_W-1:0] next_c;
    logic            lead_zero_c;

`ifdef KEYPAD_BACKSPACE_EN
    assign keys_c = {backspace, enter, clear, nine, eight, seven, six, five,
                     four, three, two, one, zero};
`else
    assign keys_c = {enter, clear, nine, eight, seven, six, five,
                     four, three, two, one, zero};
`endif

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk      (clk),
        .rst_n    (rst_n),
        .keys     (keys_c),
        .accept   (accept),
        .key_code (key_code),
        .busy     (busy)
    );

    // Widened so an out-of-range append is detected rather than wrapped.
    assign digit_c     = onehot_to_digit(key_code[KEY_NINE:KEY_ZERO]);
    assign next_c      = EXT_W'(number_q) * EXT_W'(10) + EXT_W'(digit_c);
    assign lead_zero_c = (number_q == '0) && (dc_q == '0) && (digit_c == '0);

    always_comb begin
        number_d = number_q;
        dc_d     = dc_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        valid_d  = 1'b0;
        error_d  = 1'b0;
        if (accept) begin
            if (|key_code[KEY_NINE:KEY_ZERO]) begin
                if (!lead_zero_c) begin
                    if ((dc_q == DC_W'(MAX_DIGITS)) || (next_c > EXT_MAX)) begin
                        ovf_d = 1'b1;
                    end else begin
                        number_d = next_c[NW-1:0];
                        dc_d     = dc_q + DC_W'(1);
                    end
                end
            end else if (key_code[KEY_CLEAR]) begin
                number_d = '0;
                dc_d     = '0;
                ovf_d    = 1'b0;
            end else if (key_code[KEY_ENTER]) begin
                if (ovf_q) begin
                    error_d = 1'b1;
                end else begin
                    result_d = number_q;
                    valid_d  = 1'b1;
                end
                number_d = '0;
                dc_d     = '0;
                ovf_d    = 1'b0;
`ifdef KEYPAD_BACKSPACE_EN
            end else if (key_code[KEY_BACKSPACE]) begin
                number_d = number_q / NW'(10);
                if (dc_q != '0) begin
                    dc_d = dc_q - DC_W'(1);
                end
                ovf_d = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            number_q <= '0;
            dc_q     <= '0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            number_q <= number_d;
            dc_q     <= dc_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    assign number       = number_q;
    assign digit_count  = dc_q;
    assign overflow     = ovf_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign result_error = error_q;

endmodule

// File: tb/tb_keypad_number_entry.sv
// Directed bench for keypad_number_entry: a 16-bit instance for the main
// sequences and an 8-bit instance for the value-overflow boundary.
module tb_keypad_number_entry;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] keys;

    logic [15:0] number, result;
    logic [2:0]  digit_count;
    logic        overflow, busy, result_valid, result_error;

    logic [7:0]  number8, result8;
    logic [2:0]  dc8;
    logic        ov8, busy8, rv8, re8;

    always #5 clk = ~clk;

    keypad_number_entry #(
        .NUMBER_WIDTH (16), .MAX_DIGITS (4), .DEBOUNCE_CYCLES (3)
    ) u_dut (
        .clk (clk), .rst_n (rst_n),
        .zero (keys[0]), .one (keys[1]), .two (keys[2]), .three (keys[3]),
        .four (keys[4]), .five (keys[5]), .six (keys[6]), .seven (keys[7]),
        .eight (keys[8]), .nine (keys[9]), .clear (keys[10]), .enter (keys[11]),
        .number (number), .digit_count (digit_count), .overflow (overflow),
        .busy (busy), .result (result), .result_valid (result_valid),
        .result_error (result_error)
    );

    keypad_number_entry #(
        .NUMBER_WIDTH (8), .MAX_DIGITS (4), .DEBOUNCE_CYCLES (3)
    ) u_dut8 (
        .clk (clk), .rst_n (rst_n),
        .zero (keys[0]), .one (keys[1]), .two (keys[2]), .three (keys[3]),
        .four (keys[4]), .five (keys[5]), .six (keys[6]), .seven (keys[7]),
        .eight (keys[8]), .nine (keys[9]), .clear (keys[10]), .enter (keys[11]),
        .number (number8), .digit_count (dc8), .overflow (ov8),
        .busy (busy8), .result (result8), .result_valid (rv8),
        .result_error (re8)
    );

    int checks = 0;
    int errors = 0;
    int vcnt   = 0;
    int ecnt   = 0;

    // Pulse cycle counters for the 16-bit instance.
    always @(negedge clk) begin
        if (result_valid) vcnt++;
        if (result_error) ecnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        keys  = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Hold one key for 'hold' samples, release, and let the FSM return to IDLE.
    task automatic press(input int key, input int hold);
        @(negedge clk);
        keys      = '0;
        keys[key] = 1'b1;
        repeat (hold) @(negedge clk);
        keys = '0;
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        int key;
        int num;
        int dc;
        int ov;
        int res;
        int nv;
        int ne;
    } vec_t;

    vec_t tbl[16];
    int   v0, e0;

    initial begin
        tbl[0]  = '{1,  1,    1, 0, 0,   0, 0};
        tbl[1]  = '{2,  12,   2, 0, 0,   0, 0};
        tbl[2]  = '{3,  123,  3, 0, 0,   0, 0};
        tbl[3]  = '{11, 0,    0, 0, 123, 1, 0};
        tbl[4]  = '{0,  0,    0, 0, 123, 0, 0};
        tbl[5]  = '{9,  9,    1, 0, 123, 0, 0};
        tbl[6]  = '{8,  98,   2, 0, 123, 0, 0};
        tbl[7]  = '{7,  987,  3, 0, 123, 0, 0};
        tbl[8]  = '{6,  9876, 4, 0, 123, 0, 0};
        tbl[9]  = '{5,  9876, 4, 1, 123, 0, 0};
        tbl[10] = '{11, 0,    0, 0, 123, 0, 1};
        tbl[11] = '{4,  4,    1, 0, 123, 0, 0};
        tbl[12] = '{0,  40,   2, 0, 123, 0, 0};
        tbl[13] = '{10, 0,    0, 0, 123, 0, 0};
        tbl[14] = '{5,  5,    1, 0, 123, 0, 0};
        tbl[15] = '{11, 0,    0, 0, 5,   1, 0};

        keys  = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset number",   32'(number), 0);
        check("reset digits",   32'(digit_count), 0);
        check("reset overflow", 32'(overflow), 0);
        check("reset busy",     32'(busy), 0);
        check("reset result",   32'(result), 0);
        check("reset valid",    32'(result_valid), 0);
        check("reset error",    32'(result_error), 0);
        check("reset8 outputs", 32'({number8, result8, dc8, ov8, busy8, rv8, re8}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency: key seen at edge k commits on edge k+3, number updates on edge k+4.
        keys[1] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("latency number before", 32'(number), 0);
        check("latency busy in commit", 32'(busy), 1);
        @(posedge clk);
        #1;
        check("latency number after", 32'(number), 1);
        @(negedge clk);
        keys = '0;
        repeat (3) @(negedge clk);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            v0 = vcnt;
            e0 = ecnt;
            press(tbl[i].key, 5);
            check($sformatf("vec%0d number", i),   32'(number),      32'(tbl[i].num));
            check($sformatf("vec%0d digits", i),   32'(digit_count), 32'(tbl[i].dc));
            check($sformatf("vec%0d overflow", i), 32'(overflow),    32'(tbl[i].ov));
            check($sformatf("vec%0d result", i),   32'(result),      32'(tbl[i].res));
            check($sformatf("vec%0d valid pulses", i), 32'(vcnt - v0), 32'(tbl[i].nv));
            check($sformatf("vec%0d error pulses", i), 32'(ecnt - e0), 32'(tbl[i].ne));
            check($sformatf("vec%0d busy", i),     32'(busy), 0);
        end

        // Short glitch of key 7 must not commit.
        press(4, 5);
        check("pre-glitch number", 32'(number), 4);
        v0 = vcnt;
        @(negedge clk);
        keys[7] = 1'b1;
        @(negedge clk);
        check("glitch busy", 32'(busy), 1);
        @(negedge clk);
        keys = '0;
        repeat (6) @(negedge clk);
        check("glitch number", 32'(number), 4);
        check("glitch digits", 32'(digit_count), 1);
        check("glitch busy idle", 32'(busy), 0);

        // Two keys together never start a debounce.
        keys[4] = 1'b1;
        keys[5] = 1'b1;
        repeat (5) @(negedge clk);
        check("multikey busy", 32'(busy), 0);
        repeat (5) @(negedge clk);
        keys = '0;
        repeat (3) @(negedge clk);
        check("multikey number", 32'(number), 4);
        check("multikey digits", 32'(digit_count), 1);
        check("multikey pulses", 32'(vcnt - v0), 0);

        // 8-bit value overflow: 256 > 255.
        do_reset();
        press(2, 5);
        press(5, 5);
        check("w8 number 25", 32'(number8), 25);
        press(6, 5);
        check("w8 number held", 32'(number8), 25);
        check("w8 digits", 32'(dc8), 2);
        check("w8 overflow", 32'(ov8), 1);
        check("w16 number 256", 32'(number), 256);
        check("w16 overflow", 32'(overflow), 0);

        // Reset during debounce of key 3 with number=42 and result=42.
        do_reset();
        press(4, 5);
        press(2, 5);
        press(11, 5);
        press(4, 5);
        press(2, 5);
        check("pre-reset number", 32'(number), 42);
        check("pre-reset result", 32'(result), 42);
        @(negedge clk);
        keys[3] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid-debounce busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("async reset number", 32'(number), 0);
        check("async reset digits", 32'(digit_count), 0);
        check("async reset result", 32'(result), 0);
        check("async reset busy",   32'(busy), 0);
        @(negedge clk);
        keys = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post-reset number", 32'(number), 0);
        check("post-reset digits", 32'(digit_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
